// File: rtl/display_scan_controller.sv
// Time-multiplexed 4-digit 7-segment scan controller for three BCD channels.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zeros in the tens/hundreds slots.
module display_scan_controller #(
  parameter int SCAN_DIV    = 50000,
  parameter int DWELL_SCANS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] left_bcd,
  input  logic [9:0] middle_bcd,
  input  logic [9:0] right_bcd,
  input  logic       next_channel,
  input  logic       auto_mode,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic [1:0] channel
);
  // state        | meaning
  // DIG_UNITS    | units slot lit, an_n[0] low
  // DIG_TENS     | tens slot lit, an_n[1] low
  // DIG_HUNDREDS | hundreds slot lit, an_n[2] low
  // DIG_TAG      | channel tag slot lit, an_n[3] low; leaving it is the scan boundary
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2,
    DIG_TAG      = 2'd3
  } digit_t;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_SCANS - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  logic [PW-1:0] presc;
  digit_t        digit;
  digit_t        digit_next;
  logic [9:0]    snapshot;
  logic          pending;
  logic [DW-1:0] dwell;
  logic          nc_prev;

  logic       slot_end, boundary, rise, advance;
  logic [1:0] chan_next;
  logic [9:0] live_bcd, shown_bcd;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  always_comb begin
    slot_end   = (presc == PRESC_LAST);
    digit_next = digit_t'(digit + 2'd1);
    boundary   = slot_end && (digit == DIG_TAG);
    rise       = next_channel && !nc_prev;
    advance    = pending || (auto_mode && (dwell == DWELL_LAST));
    chan_next  = channel;
    if (advance) chan_next = (channel == 2'd2) ? 2'd0 : channel + 2'd1;
    case (chan_next)
      2'd0:    live_bcd = left_bcd;
      2'd1:    live_bcd = middle_bcd;
      default: live_bcd = right_bcd;
    endcase
    // the boundary edge shows the freshly sampled value, not the stale snapshot
    shown_bcd = boundary ? live_bcd : snapshot;
    an_next   = ~(4'b0001 << digit_next);
    case (digit_next)
      DIG_UNITS: seg_next = seg_digit(shown_bcd[3:0]);
      DIG_TENS: begin
        if (BLANK_EN && shown_bcd[9:8] == 2'd0 && shown_bcd[7:4] == 4'd0) seg_next = SEG_BLANK;
        else seg_next = seg_digit(shown_bcd[7:4]);
      end
      DIG_HUNDREDS: begin
        if (BLANK_EN && shown_bcd[9:8] == 2'd0) seg_next = SEG_BLANK;
        else if (shown_bcd[9:8] == 2'd3) seg_next = SEG_DASH;
        else seg_next = seg_digit({2'b00, shown_bcd[9:8]});
      end
      default: begin
        case (channel)
          2'd0:    seg_next = 7'b1000111;
          2'd1:    seg_next = 7'b1000110;
          default: seg_next = 7'b0101111;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc    <= PRESC_LAST;
      digit    <= DIG_TAG;
      an_n     <= 4'b1111;
      seg_n    <= SEG_BLANK;
      channel  <= 2'd0;
      snapshot <= '0;
      pending  <= 1'b0;
      dwell    <= '0;
      nc_prev  <= 1'b0;
    end else begin
      nc_prev <= next_channel;
      if (!auto_mode) dwell <= '0;
      if (rise) pending <= 1'b1;
      if (slot_end) begin
        presc <= '0;
        digit <= digit_next;
        an_n  <= an_next;
        seg_n <= seg_next;
        if (boundary) begin
          channel  <= chan_next;
          snapshot <= live_bcd;
          // an edge on the boundary cycle itself waits for the next boundary
          pending  <= rise;
          if (advance) dwell <= '0;
          else if (auto_mode) dwell <= dwell + 1'b1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_display_scan_controller.sv
// Self-checking bench for display_scan_controller: scan-level reference model plus directed and random stimulus.
// Build with LEADING_ZERO_BLANK_EN defined to check the blanking variant.
module tb_display_scan_controller;
  localparam int SCAN_DIV    = 4;
  localparam int DWELL_SCANS = 3;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] OFF  = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] left_bcd = '0, middle_bcd = '0, right_bcd = '0;
  logic       next_channel = 1'b0, auto_mode = 1'b0;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic [1:0] channel;

  display_scan_controller #(.SCAN_DIV(SCAN_DIV), .DWELL_SCANS(DWELL_SCANS)) dut (
    .clk(clk), .rst(rst), .left_bcd(left_bcd), .middle_bcd(middle_bcd), .right_bcd(right_bcd),
    .next_channel(next_channel), .auto_mode(auto_mode), .an_n(an_n), .seg_n(seg_n), .channel(channel)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [6:0] tag [3]  = '{7'b1000111, 7'b1000110, 7'b0101111};

  // reference model state: edges since reset release, channel, shown value, request bookkeeping
  int         m_cyc = 0, m_chan = 0, m_dwell = 0, m_digit = 3;
  logic [9:0] m_snap = '0;
  bit         m_req = 0, m_prev = 0;

  function automatic logic [12:0] exp_out();
    int h, t, u;
    logic [6:0] seg;
    if (!rst || m_cyc == 0) return {4'hF, OFF, 2'd0};
    h = int'(m_snap[9:8]);
    t = int'(m_snap[7:4]);
    u = int'(m_snap[3:0]);
    case (m_digit)
      0: seg = (u > 9) ? DASH : pat[u];
      1: seg = (BLANK && h == 0 && t == 0) ? OFF : (t > 9) ? DASH : pat[t];
      2: seg = (BLANK && h == 0) ? OFF : (h == 3) ? DASH : pat[h];
      default: seg = tag[m_chan];
    endcase
    return {~(4'b0001 << m_digit), seg, 2'(m_chan)};
  endfunction

  function automatic logic [9:0] rnd_bcd();
    if ($urandom_range(0, 3) == 0) return 10'($urandom);
    return {2'($urandom_range(0, 2)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic tick();
    int pos, dig;
    bit rise, adv;
    @(posedge clk);
    if (!rst) begin
      m_cyc = 0; m_chan = 0; m_dwell = 0; m_digit = 3;
      m_snap = '0; m_req = 0; m_prev = 0;
    end else begin
      m_cyc++;
      pos  = (m_cyc - 1) % SCAN_DIV;
      dig  = ((m_cyc - 1) / SCAN_DIV) % 4;
      rise = next_channel && !m_prev;
      if (pos == 0 && dig == 0) begin
        adv = m_req || (auto_mode && m_dwell == DWELL_SCANS - 1);
        if (adv) begin
          m_chan  = (m_chan + 1) % 3;
          m_dwell = 0;
        end else if (auto_mode) m_dwell++;
        else m_dwell = 0;
        m_snap = (m_chan == 0) ? left_bcd : (m_chan == 1) ? middle_bcd : right_bcd;
        m_req  = rise;
      end else begin
        m_req = m_req || rise;
        if (!auto_mode) m_dwell = 0;
      end
      m_prev  = next_channel;
      m_digit = dig;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] obs, exp;
    left_bcd = 10'h125; middle_bcd = 10'h007; right_bcd = 10'h042;
    next_channel = 0; auto_mode = 0;
    #1 rst = 0;
    #1;
    obs = {an_n, seg_n, channel}; vectors++;
    if (obs !== {4'hF, OFF, 2'd0}) begin
      miscompares++; $display("FAIL reset_async got=%b want=%b", obs, {4'hF, OFF, 2'd0});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL reset_hold got=%b want=%b", obs, exp); end
    end
  endtask

  task automatic test_scan_sequence();
    logic [12:0] obs, exp;
    logic [12:0] plan [4];
    plan = '{{4'b1110, 7'b0010010, 2'd0}, {4'b1101, 7'b0100100, 2'd0},
             {4'b1011, 7'b1111001, 2'd0}, {4'b0111, 7'b1000111, 2'd0}};
    rst = 1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL scan_model cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
      if (i % 4 == 1) begin
        vectors++;
        if (obs !== plan[i / 4]) begin
          miscompares++; $display("FAIL scan_plan cyc=%0d got=%b want=%b", m_cyc, obs, plan[i / 4]);
        end
      end
    end
  endtask

  task automatic test_manual_advance();
    logic [12:0] obs, exp;
    for (int i = 0; i < 16; i++) begin
      next_channel = (i == 3 || i == 6);
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL manual_pulse cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
    end
    next_channel = 0;
    vectors++;
    if (channel !== 2'd0) begin miscompares++; $display("FAIL manual_wait got=%0d want=0", channel); end
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL manual_adv cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
      if (i == 0 || i == 15) begin
        exp = (i == 0) ? {4'b1110, 7'b1111000, 2'd1} : {4'b0111, 7'b1000110, 2'd1};
        vectors++;
        if (obs !== exp) begin miscompares++; $display("FAIL manual_plan cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
      end
    end
    next_channel = 1;
    for (int i = 0; i < 64; i++) begin
      if (i == 48) next_channel = 0;
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL manual_held cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
    end
    vectors++;
    if (channel !== 2'd2) begin miscompares++; $display("FAIL manual_held_once got=%0d want=2", channel); end
  endtask

  task automatic test_auto();
    logic [12:0] obs, exp;
    int last_change = 0, changes = 0, adv_seen = 0, prev_model = m_chan;
    logic [1:0] last_ch = channel;
    bit pulsed = 0;
    auto_mode = 1;
    for (int i = 0; i < 192; i++) begin
      next_channel = (!pulsed && adv_seen >= 2 && m_dwell == DWELL_SCANS - 1 && m_digit == 1);
      if (next_channel) pulsed = 1;
      tick();
      if (m_chan != prev_model) begin adv_seen++; prev_model = m_chan; end
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL auto_model cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
      if (channel !== last_ch) begin
        if (changes > 0) begin
          vectors++;
          if (m_cyc - last_change !== 48) begin
            miscompares++; $display("FAIL auto_interval got=%0d want=48", m_cyc - last_change);
          end
        end
        changes++; last_change = m_cyc; last_ch = channel;
      end
    end
    next_channel = 0; auto_mode = 0;
    vectors++;
    if (changes !== 4) begin miscompares++; $display("FAIL auto_count got=%0d want=4", changes); end
  endtask

  task automatic test_async_reset();
    logic [12:0] obs, exp;
    for (int i = 0; i < 80 && !(m_digit == 2 && (m_cyc - 1) % SCAN_DIV == 1); i++) tick();
    vectors++;
    if (!(m_digit == 2 && (m_cyc - 1) % SCAN_DIV == 1)) begin
      miscompares++; $display("FAIL async_reach got=%0d want=2", m_digit);
    end
    #2 rst = 0;
    #1;
    obs = {an_n, seg_n, channel}; vectors++;
    if (obs !== {4'hF, OFF, 2'd0}) begin
      miscompares++; $display("FAIL async_reset got=%b want=%b", obs, {4'hF, OFF, 2'd0});
    end
    tick();
    rst = 1;
    tick();
    obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL async_release got=%b want=%b", obs, exp); end
    vectors++;
    if (obs !== {4'b1110, 7'b0010010, 2'd0}) begin
      miscompares++; $display("FAIL async_first got=%b want=%b", obs, {4'b1110, 7'b0010010, 2'd0});
    end
  endtask

  task automatic test_midscan_change();
    logic [12:0] obs, exp;
    logic [6:0] want;
    int s;
    for (int i = 0; i < 100 && m_cyc < 48; i++) begin
      if (m_digit == 1 && m_cyc < 16) left_bcd = 10'h200;
      if (m_cyc == 24) left_bcd = 10'h1A5;
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL midscan_model cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
      s = (m_cyc - 1) / 16;
      want = OFF;
      if (s == 0 && m_digit == 2) want = 7'b1111001;
      if (s == 1 && m_digit == 0) want = 7'b1000000;
      if (s == 1 && m_digit == 2) want = 7'b0100100;
      if (s == 2 && m_digit == 1) want = DASH;
      if (want !== OFF) begin
        vectors++;
        if (seg_n !== want) begin miscompares++; $display("FAIL midscan_plan cyc=%0d got=%b want=%b", m_cyc, seg_n, want); end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [12:0] obs, exp;
    logic [6:0] want;
    left_bcd = 10'h007;
    for (int i = 0; i < 16; i++) begin
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL lzb_model cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
      if (m_digit < 3) begin
        want = (m_digit == 0) ? 7'b1111000 : (BLANK ? OFF : 7'b1000000);
        vectors++;
        if (seg_n !== want) begin miscompares++; $display("FAIL lzb_plan digit=%0d got=%b want=%b", m_digit, seg_n, want); end
      end
    end
  endtask

  task automatic test_random();
    logic [12:0] obs, exp;
    for (int i = 0; i < 640; i++) begin
      if ($urandom_range(0, 11) == 0) left_bcd = rnd_bcd();
      if ($urandom_range(0, 11) == 0) middle_bcd = rnd_bcd();
      if ($urandom_range(0, 11) == 0) right_bcd = rnd_bcd();
      if ($urandom_range(0, 5) == 0) next_channel = ~next_channel;
      if ($urandom_range(0, 63) == 0) auto_mode = ~auto_mode;
      tick();
      obs = {an_n, seg_n, channel}; exp = exp_out(); vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL random cyc=%0d got=%b want=%b", m_cyc, obs, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_scan_sequence();
    test_manual_advance();
    test_auto();
    test_async_reset();
    test_midscan_change();
    test_leading_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
